// File: rtl/rvfi_mon_pkg.sv
// Shared types and helpers for the RVFI commit-stream monitor.
// Provides the tracker FSM encoding, a lane popcount and the lane-slice
// offset helper used on the packed pc/order buses.
package rvfi_mon_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTED  = 2'd1,
    TIMEOUT = 2'd2
  } tracker_state_t;

  // Widest lane vector the popcount helper accepts (NUM_LANES must not exceed it).
  localparam int MAX_LANES = 32;

  // Width of a single PC field on the packed pc_rdata/pc_wdata buses.
  localparam int PC_W = 32;

  // Number of set bits in a lane vector, zero-extended to MAX_LANES.
  function automatic logic [5:0] popcount(input logic [MAX_LANES-1:0] bits);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      cnt = cnt + 6'(bits[i]);
    end
    return cnt;
  endfunction

  // Bit offset of lane 'lane' on a packed bus whose fields are 'width' bits.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/commit_order_gen.sv
// Purely combinational order generator: each lane gets the registered base
// plus the number of valid lanes older than it, and the cycle total is the
// popcount of all valid lanes.
module commit_order_gen
  import rvfi_mon_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int ORDER_W   = 64
) (
  input  logic [ORDER_W-1:0]           total_commits,
  input  logic [NUM_LANES-1:0]         commit_valid,
  output logic [NUM_LANES*ORDER_W-1:0] order,
  output logic [ORDER_W-1:0]           cycle_count
);

  logic [ORDER_W-1:0] prefix;

  // Running prefix count over lanes in program order (lane 0 oldest).
  always_comb begin
    prefix = '0;
    order  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      order[lane_lsb(i, ORDER_W) +: ORDER_W] = total_commits + prefix;
      if (commit_valid[i]) begin
        prefix = prefix + ORDER_W'(1);
      end
    end
    cycle_count = prefix;
  end

endmodule

// File: rtl/rvfi_commit_tracker.sv
// Multi-lane RVFI commit tracker: assigns per-lane order numbers, counts
// retired instructions, detects a debounced self-loop halt and a no-commit
// watchdog, and reports a sticky RUN/HALTED/TIMEOUT status.
module rvfi_commit_tracker
  import rvfi_mon_pkg::*;
#(
  parameter int NUM_LANES      = 2,
  parameter int ORDER_W        = 64,
  parameter int HALT_REPEAT    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [NUM_LANES-1:0]         commit_valid,
  input  logic [NUM_LANES*32-1:0]      pc_rdata,
  input  logic [NUM_LANES*32-1:0]      pc_wdata,
  output logic [NUM_LANES*ORDER_W-1:0] order,
  output logic [ORDER_W-1:0]           total_commits,
  output logic                         halt,
  output logic                         timeout,
  output logic [1:0]                   state
);

  localparam int LOOP_W = $clog2(HALT_REPEAT + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  tracker_state_t       state_q;
  logic [LOOP_W-1:0]    loop_cnt;
  logic [LOOP_W-1:0]    loop_cnt_next;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [IDLE_W-1:0]    idle_cnt_next;
  logic [ORDER_W-1:0]   cycle_count;
  logic [NUM_LANES-1:0] loop_lane;
  logic [NUM_LANES-1:0] non_loop_lane;
  logic                 halt_hit;
  logic                 idle_hit;
  int                   loop_tail;
  int                   loop_sum;

  assign state = state_q;

  commit_order_gen #(
    .NUM_LANES (NUM_LANES),
    .ORDER_W   (ORDER_W)
  ) u_order_gen (
    .total_commits (total_commits),
    .commit_valid  (commit_valid),
    .order         (order),
    .cycle_count   (cycle_count)
  );

  // Classify each valid lane as a self-loop (jumps to itself) or not.
  always_comb begin
    loop_lane = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      loop_lane[i] = commit_valid[i] &&
                     (pc_wdata[lane_lsb(i, PC_W) +: PC_W] ==
                      pc_rdata[lane_lsb(i, PC_W) +: PC_W]);
    end
    non_loop_lane = commit_valid & ~loop_lane;
  end

  // Next self-loop streak: extend it, restart after the youngest non-loop lane, or hold.
  always_comb begin
    loop_tail = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (non_loop_lane[i]) begin
        loop_tail = 0;
      end else if (loop_lane[i]) begin
        loop_tail = loop_tail + 1;
      end
    end
    if (commit_valid == '0) begin
      loop_sum = int'(loop_cnt);
    end else if (non_loop_lane == '0) begin
      loop_sum = int'(loop_cnt) + int'(popcount(MAX_LANES'(commit_valid)));
    end else begin
      loop_sum = loop_tail;
    end
    if (loop_sum > HALT_REPEAT) begin
      loop_sum = HALT_REPEAT;
    end
    loop_cnt_next = LOOP_W'(loop_sum);
    halt_hit      = (loop_sum >= HALT_REPEAT);
  end

  // Next idle count: any commit restarts it, otherwise count up to the watchdog limit.
  always_comb begin
    if (|commit_valid) begin
      idle_cnt_next = '0;
    end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES)) begin
      idle_cnt_next = idle_cnt;
    end else begin
      idle_cnt_next = idle_cnt + IDLE_W'(1);
    end
    idle_hit = (idle_cnt_next == IDLE_W'(TIMEOUT_CYCLES));
  end

  // Counters and sticky status FSM; clear restarts everything and wins over commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      total_commits <= '0;
      loop_cnt      <= '0;
      idle_cnt      <= '0;
      halt          <= 1'b0;
      timeout       <= 1'b0;
    end else if (clear) begin
      state_q       <= RUN;
      total_commits <= '0;
      loop_cnt      <= '0;
      idle_cnt      <= '0;
      halt          <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          total_commits <= total_commits + cycle_count;
          loop_cnt      <= loop_cnt_next;
          idle_cnt      <= idle_cnt_next;
          if (halt_hit) begin
            state_q <= HALTED;
            halt    <= 1'b1;
          end else if (idle_hit) begin
            state_q <= TIMEOUT;
            timeout <= 1'b1;
          end
        end
        HALTED, TIMEOUT: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Self-checking bench for rvfi_commit_tracker: directed scenarios followed by
// randomized commit traffic, compared against a commit-stream reference model.
module tb_rvfi_commit_tracker;

  localparam int N  = 2;
  localparam int OW = 64;
  localparam int HR = 2;
  localparam int TO = 16;

  logic            clk;
  logic            rst;
  logic            clear;
  logic [N-1:0]    commit_valid;
  logic [N*32-1:0] pc_rdata;
  logic [N*32-1:0] pc_wdata;
  logic [N*OW-1:0] order;
  logic [OW-1:0]   total_commits;
  logic            halt;
  logic            timeout;
  logic [1:0]      state;

  int checkCount;
  int errorCount;

  // Reference model: retired instruction count, trailing self-loop streak in
  // program order, consecutive idle cycles and the status (0 run, 1 halted, 2 timeout).
  logic [63:0] mCommits;
  int          mStreak;
  int          mIdle;
  int          mState;

  rvfi_commit_tracker #(
    .NUM_LANES      (N),
    .ORDER_W        (OW),
    .HALT_REPEAT    (HR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .commit_valid  (commit_valid),
    .pc_rdata      (pc_rdata),
    .pc_wdata      (pc_wdata),
    .order         (order),
    .total_commits (total_commits),
    .halt          (halt),
    .timeout       (timeout),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mCommits = '0;
    mStreak  = 0;
    mIdle    = 0;
    mState   = 0;
  endtask

  task automatic modelStep(input logic [N-1:0] valid, input logic [N*32-1:0] pcr,
                           input logic [N*32-1:0] pcw, input logic clr);
    bit any;
    if (clr) begin
      modelReset();
    end else if (mState == 0) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (valid[i]) begin
          any = 1'b1;
          mCommits = mCommits + 64'd1;
          if (pcw[i*32 +: 32] == pcr[i*32 +: 32]) mStreak = mStreak + 1;
          else mStreak = 0;
        end
      end
      if (any) mIdle = 0;
      else mIdle = mIdle + 1;
      if (mStreak >= HR) mState = 1;
      else if (mIdle >= TO) mState = 2;
    end
  endtask

  task automatic checkRegs();
    checkOutput("total_commits", total_commits, mCommits);
    checkOutput("halt", 64'(halt), 64'(mState == 1));
    checkOutput("timeout", 64'(timeout), 64'(mState == 2));
    checkOutput("state", 64'(state), 64'(mState));
  endtask

  task automatic buildPcs(input logic [N-1:0] loopMask, output logic [N*32-1:0] pcr,
                          output logic [N*32-1:0] pcw);
    logic [31:0] base;
    for (int i = 0; i < N; i++) begin
      base = $urandom & 32'hFFFF_FFFC;
      pcr[i*32 +: 32] = base;
      pcw[i*32 +: 32] = loopMask[i] ? base : base + 32'd4;
    end
  endtask

  // Drive one cycle of inputs, check combinational orders, then registered outputs.
  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N*32-1:0] pcr,
                               input logic [N*32-1:0] pcw, input logic clr);
    logic [63:0] k;
    commit_valid = valid;
    pc_rdata     = pcr;
    pc_wdata     = pcw;
    clear        = clr;
    #1;
    k = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i]) begin
        checkOutput($sformatf("order%0d", i), order[i*OW +: OW], mCommits + k);
        k = k + 64'd1;
      end
    end
    @(posedge clk);
    modelStep(valid, pcr, pcw, clr);
    @(negedge clk);
    checkRegs();
  endtask

  initial begin
    logic [N*32-1:0] pcr;
    logic [N*32-1:0] pcw;
    logic [N-1:0]    valid;
    logic [N-1:0]    loopMask;
    logic            clr;
    int              idleLeft;

    checkCount   = 0;
    errorCount   = 0;
    rst          = 1'b1;
    clear        = 1'b0;
    commit_valid = '0;
    pc_rdata     = '0;
    pc_wdata     = '0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkRegs();

    // Idle after reset.
    repeat (3) applyStimulus(2'b00, '0, '0, 1'b0);
    checkOutput("reset_idle_total", total_commits, 64'd0);
    checkOutput("reset_idle_state", 64'(state), 64'd0);

    // Two non-loop commits per cycle.
    for (int c = 0; c < 3; c++) begin
      pcr = {32'h0000_2000 + 32'(c * 16), 32'h0000_1000 + 32'(c * 16)};
      pcw = {pcr[63:32] + 32'd4, pcr[31:0] + 32'd4};
      applyStimulus(2'b11, pcr, pcw, 1'b0);
    end
    checkOutput("plan_total6", total_commits, 64'd6);

    // Gap in lane 0: lane 1 takes the base order.
    commit_valid = 2'b10;
    #1;
    checkOutput("plan_gap_order1", order[OW +: OW], 64'd6);
    applyStimulus(2'b10, {32'h0000_3000, 32'h0}, {32'h0000_3004, 32'h4}, 1'b0);
    checkOutput("plan_total7", total_commits, 64'd7);

    // Debounced self-loop halt.
    applyStimulus(2'b11, {32'h6000_0040, 32'h0000_1000},
                  {32'h6000_0040, 32'h0000_1004}, 1'b0);
    checkOutput("plan_halt0", 64'(halt), 64'd0);
    applyStimulus(2'b01, {32'h0, 32'h6000_0040}, {32'h0, 32'h6000_0040}, 1'b0);
    checkOutput("plan_halt1", 64'(halt), 64'd1);
    checkOutput("plan_halt_state", 64'(state), 64'd1);
    applyStimulus(2'b11, {32'h100, 32'h200}, {32'h104, 32'h204}, 1'b0);
    checkOutput("plan_frozen", total_commits, 64'd10);

    // Clear while halted, with commits that must not count.
    applyStimulus(2'b11, {32'h100, 32'h200}, {32'h104, 32'h204}, 1'b1);
    checkOutput("plan_clear_total", total_commits, 64'd0);
    checkOutput("plan_clear_state", 64'(state), 64'd0);

    // Watchdog.
    applyStimulus(2'b01, {32'h0, 32'h500}, {32'h0, 32'h504}, 1'b0);
    repeat (15) applyStimulus(2'b00, '0, '0, 1'b0);
    checkOutput("plan_wd15", 64'(timeout), 64'd0);
    applyStimulus(2'b00, '0, '0, 1'b0);
    checkOutput("plan_wd16", 64'(timeout), 64'd1);
    checkOutput("plan_wd_state", 64'(state), 64'd2);
    applyStimulus(2'b01, {32'h0, 32'h600}, {32'h0, 32'h604}, 1'b0);
    checkOutput("plan_wd_sticky", 64'(timeout), 64'd1);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_total", total_commits, 64'd0);
    checkOutput("async_timeout", 64'(timeout), 64'd0);
    checkOutput("async_halt", 64'(halt), 64'd0);
    checkOutput("async_state", 64'(state), 64'd0);
    rst = 1'b0;
    modelReset();

    // Randomized traffic with idle bursts and occasional restarts.
    idleLeft = 0;
    for (int c = 0; c < 800; c++) begin
      clr = ((mState != 0) && ($urandom_range(0, 5) == 0)) || ($urandom_range(0, 99) == 0);
      if (idleLeft > 0) begin
        valid    = '0;
        idleLeft = idleLeft - 1;
      end else begin
        valid = N'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) idleLeft = $urandom_range(8, 20);
      end
      for (int i = 0; i < N; i++) loopMask[i] = ($urandom_range(0, 4) == 0);
      buildPcs(loopMask, pcr, pcw);
      applyStimulus(valid, pcr, pcw, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_tracker.md
Name: rvfi_commit_tracker

Overview:
Synthesisable commit-stream monitor for the mp4 RISC-V core and its verification top. It generalises single-lane commit ordering and infinite-loop halt detection to NUM_LANES commits per cycle, as needed for superscalar/OoO retirement. It also adds a debounced self-loop halt, a no-commit watchdog and a sticky status FSM. It sits between the core's retirement stage and the RVFI monitor, driving each lane's order, halt and a timeout flag.

Parameters:
NUM_LANES, 2, commit lanes per cycle; lane 0 is oldest in program order.
ORDER_W, 64, width of order and commit counters.
HALT_REPEAT, 2, consecutive self-loop commits required to declare halt (>=1).
TIMEOUT_CYCLES, 1024, consecutive commit-free cycles that trip the watchdog (>=1).

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous, active-high.
clear  in  1  synchronous restart of all counters/FSM; same effect as reset.
commit_valid  in  NUM_LANES  per-lane commit strobe.
pc_rdata  in  NUM_LANES*32  PC of each committing instruction; lane i at [32i+31:32i].
pc_wdata  in  NUM_LANES*32  next PC of each committing instruction.
order  out  NUM_LANES*ORDER_W  RVFI order per lane; valid only where commit_valid set.
total_commits  out  ORDER_W  committed instructions before this cycle (registered order base).
halt  out  1  sticky; detected infinite self-loop.
timeout  out  1  sticky; watchdog expired.
state  out  2  FSM state: 0 RUN, 1 HALTED, 2 TIMEOUT.

Behaviour:
- Reset/clear: total_commits=0, loop_cnt=0, idle_cnt=0, state=RUN, halt=0, timeout=0. clear has priority over all same-cycle commits; commits in a clear cycle are not counted.
- order[i] is combinational: total_commits + popcount(commit_valid[i-1:0]). Invalid lanes carry the same formula; it is don't-care for checking.
- Every edge in RUN: total_commits += popcount(commit_valid), wrapping modulo 2^ORDER_W.
- Self-loop lane: commit_valid[i] && pc_wdata[i]==pc_rdata[i].
- loop_cnt update per cycle:
  - If no lanes are valid: hold.
  - If all valid lanes are self-loops: loop_cnt += count of valid lanes.
  - Otherwise: loop_cnt = count of self-loop lanes above the highest-indexed valid non-loop lane.
  - Saturates at HALT_REPEAT.
- idle_cnt: reset to 0 on any valid lane; otherwise increments, saturating at TIMEOUT_CYCLES.
- FSM:
  - RUN->HALTED when next loop_cnt >= HALT_REPEAT. halt rises on that same edge, visible the cycle after the qualifying commit.
  - RUN->TIMEOUT when next idle_cnt == TIMEOUT_CYCLES. timeout rises on that edge.
  - If both conditions would trigger on one edge, HALTED wins. In practice they are mutually exclusive, since halting requires a commit.
  - HALTED and TIMEOUT are absorbing until rst or clear. In both, all counters freeze: total_commits, loop_cnt and idle_cnt hold, and further commits are ignored.
- Registered outputs (total_commits, halt, timeout, state) have no combinational path from inputs. order is the only combinational output.
- Reset asserted mid-operation returns everything to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package rvfi_mon_pkg holds:
  - tracker_state_t enum {RUN=2'd0, HALTED=2'd1, TIMEOUT=2'd2};
  - a popcount function;
  - the lane-slice helper for packed pc/order buses.
- One natural sub-module: commit_order_gen. It is purely combinational: prefix popcount producing per-lane order and the cycle total. The parent owns all registers and the FSM.

Test Plan:
- Reset then idle 3 cycles -> halt=0, timeout=0, state=0, total_commits=0.
- N=2, valid=2'b11 for 3 cycles with non-loop PCs (pc_wdata=pc_rdata+4) -> orders {0,1},{2,3},{4,5}; total_commits=6 afterwards.
- Gap lanes: valid=2'b10 at total_commits=6 -> order[1]=6; total_commits=7 next cycle.
- Halt debounce, HALT_REPEAT=2:
  - Cycle A: lane0 non-loop plus lane1 self-loop at pc=0x60000040 -> loop_cnt=1, halt=0.
  - Next cycle: lane0 self-loop -> halt=1, state=1.
  - Later commits leave total_commits frozen.
- Watchdog, TIMEOUT_CYCLES=16: after the last commit, 15 idle cycles give timeout=0. The 16th idle edge gives timeout=1, state=2. A commit on the next cycle does not clear it.
- clear asserted with valid=2'b11 while HALTED -> next cycle state=0, halt=0, total_commits=0 (commits not counted). Async rst pulse between clock edges zeroes all registered outputs immediately.
